// File: rtl/net_pkg.sv
// Shared NIC network definitions: flit widths, flit record and rate-limiter FSM states.
package net_pkg;

    localparam int unsigned NET_DATA_W   = 64;
    localparam int unsigned NET_KEEP_W   = 8;
    localparam int unsigned NET_RLIMIT_W = 8;

    typedef struct packed {
        logic [NET_DATA_W-1:0] data;
        logic [NET_KEEP_W-1:0] keep;
        logic                  last;
    } net_flit_t;

    typedef enum logic {
        RL_IDLE,
        RL_IN_PKT
    } rl_state_e;

endpackage

// File: rtl/rl_token_bucket.sv
// Token bucket core: period counter, refill tick and saturating token count.
module rl_token_bucket
    import net_pkg::*;
#(
    parameter int unsigned CFG_W = NET_RLIMIT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CFG_W-1:0] inc_i,
    input  logic [CFG_W-1:0] period_i,
    input  logic [CFG_W-1:0] size_i,
    input  logic             fire_i,
    output logic             tok_nonzero_o
);

    logic [CFG_W-1:0] pcnt_q, pcnt_d;
    logic [CFG_W:0]   tok_q, tok_d;
    logic [CFG_W+1:0] tok_sum;
    logic             tick;

    always_comb begin
        tick   = (pcnt_q == period_i);
        pcnt_d = tick ? '0 : pcnt_q + CFG_W'(1);
        // Consume and refill are combined first, then saturated; two extra bits avoid overflow.
        tok_sum = {1'b0, tok_q}
                - {{(CFG_W + 1){1'b0}}, fire_i}
                + (tick ? {2'b00, inc_i} : '0);
        tok_d = (tok_sum > {2'b00, size_i}) ? {1'b0, size_i} : tok_sum[CFG_W:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q <= '0;
            tok_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            tok_q  <= tok_d;
        end
    end

    assign tok_nonzero_o = |tok_q;

endmodule

// File: rtl/net_rate_limiter.sv
// Token-bucket rate limiter on the NIC transmit flit stream; settings change only between packets.
module net_rate_limiter
    import net_pkg::*;
#(
    parameter int unsigned DATA_W = NET_DATA_W,
    parameter int unsigned KEEP_W = NET_KEEP_W,
    parameter int unsigned CFG_W  = NET_RLIMIT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CFG_W-1:0]  rlimit_inc,
    input  logic [CFG_W-1:0]  rlimit_period,
    input  logic [CFG_W-1:0]  rlimit_size,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last
);

    rl_state_e        state_q, state_d;
    logic [CFG_W-1:0] inc_q, period_q, size_q;
    logic [CFG_W-1:0] inc_act, period_act, size_act;
    logic             tok_nonzero;
    logic             fire;

    always_ff @(posedge clock) begin
        if (reset) begin
            inc_q    <= '0;
            period_q <= '0;
            size_q   <= '0;
        end else if (state_q == RL_IDLE) begin
            inc_q    <= rlimit_inc;
            period_q <= rlimit_period;
            size_q   <= rlimit_size;
        end
    end

    // Idle shadows are transparent so new settings act at once; mid-packet the captured copy rules.
    always_comb begin
        inc_act    = (state_q == RL_IDLE) ? rlimit_inc    : inc_q;
        period_act = (state_q == RL_IDLE) ? rlimit_period : period_q;
        size_act   = (state_q == RL_IDLE) ? rlimit_size   : size_q;
    end

    rl_token_bucket #(
        .CFG_W (CFG_W)
    ) u_bucket (
        .clock         (clock),
        .reset         (reset),
        .inc_i         (inc_act),
        .period_i      (period_act),
        .size_i        (size_act),
        .fire_i        (fire),
        .tok_nonzero_o (tok_nonzero)
    );

    always_comb begin
        out_valid = in_valid & tok_nonzero & ~reset;
        in_ready  = out_ready & tok_nonzero & ~reset;
        fire      = out_valid & out_ready;
        out_data  = in_data;
        out_keep  = in_keep;
        out_last  = in_last;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RL_IDLE:   if (fire && !in_last) state_d = RL_IN_PKT;
            RL_IN_PKT: if (fire && in_last)  state_d = RL_IDLE;
            default:   state_d = RL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_net_rate_limiter.sv
// Directed bench for net_rate_limiter: per-cycle vector table plus multi-cycle rate sequences.
module tb_net_rate_limiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rlimit_inc, rlimit_period, rlimit_size;
    logic        in_valid, in_ready, in_last;
    logic [63:0] in_data, out_data;
    logic [7:0]  in_keep, out_keep;
    logic        out_valid, out_ready, out_last;

    int checks = 0;
    int errors = 0;
    int fire_cyc[32];
    int n_fired;

    typedef struct {
        bit iv;
        bit ordy;
        bit last;
        bit ov;
        bit ir;
    } vec_t;

    vec_t vecs[14];

    net_rate_limiter #(
        .DATA_W (64),
        .KEEP_W (8),
        .CFG_W  (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rlimit_inc    (rlimit_inc),
        .rlimit_period (rlimit_period),
        .rlimit_size   (rlimit_size),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_keep       (in_keep),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_last      (out_last)
    );

    always #5 clock = ~clock;

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int inc, input int period, input int size);
        rlimit_inc    = 8'(inc);
        rlimit_period = 8'(period);
        rlimit_size   = 8'(size);
    endtask

    // Leaves the bench at drive time of cycle 0 (first cycle after reset).
    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_last   = 1'b0;
        in_data   = '0;
        in_keep   = '1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Streams n flits; records the cycle of each fire relative to the call.
    task automatic run_stream(input int n, input int pkt_len, input int start_cyc,
                              input int ordy_cyc, input int chg_idx, input int chg_inc,
                              input int budget);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < budget) begin
            in_valid  = (cyc >= start_cyc);
            out_ready = (cyc >= ordy_cyc);
            in_data   = 64'hA5A5_0000_0000_0000 | 64'(idx);
            in_keep   = 8'(idx + 1);
            in_last   = ((idx % pkt_len) == pkt_len - 1);
            if (idx == chg_idx) rlimit_inc = 8'(chg_inc);
            @(negedge clock);
            if (out_valid && out_ready) begin
                check_v("flit_data", out_data, 64'hA5A5_0000_0000_0000 | 64'(idx));
                check_v("flit_keep", 64'(out_keep), 64'(idx + 1));
                check_b("flit_last", out_last, ((idx % pkt_len) == pkt_len - 1));
                fire_cyc[idx] = cyc;
                idx++;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        n_fired  = idx;
        in_valid = 1'b0;
        check_i("fire_count", n_fired, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int exp_c;

        // Per-cycle table with inc=1, period=1, size=2: ticks land on odd cycles.
        vecs[0]  = '{iv: 1, ordy: 1, last: 0, ov: 0, ir: 0};
        vecs[1]  = '{iv: 1, ordy: 1, last: 0, ov: 0, ir: 0};
        vecs[2]  = '{iv: 0, ordy: 1, last: 0, ov: 0, ir: 1};
        vecs[3]  = '{iv: 1, ordy: 0, last: 0, ov: 1, ir: 0};
        vecs[4]  = '{iv: 0, ordy: 0, last: 0, ov: 0, ir: 0};
        vecs[5]  = '{iv: 0, ordy: 1, last: 0, ov: 0, ir: 1};
        vecs[6]  = '{iv: 1, ordy: 1, last: 0, ov: 1, ir: 1};
        vecs[7]  = '{iv: 1, ordy: 1, last: 0, ov: 1, ir: 1};
        vecs[8]  = '{iv: 1, ordy: 1, last: 0, ov: 1, ir: 1};
        vecs[9]  = '{iv: 1, ordy: 1, last: 0, ov: 0, ir: 0};
        vecs[10] = '{iv: 1, ordy: 1, last: 1, ov: 1, ir: 1};
        vecs[11] = '{iv: 1, ordy: 1, last: 0, ov: 0, ir: 0};
        vecs[12] = '{iv: 1, ordy: 0, last: 0, ov: 1, ir: 0};
        vecs[13] = '{iv: 1, ordy: 1, last: 1, ov: 1, ir: 1};

        set_cfg(1, 1, 2);
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_last   = 1'b0;
        in_data   = 64'h1234;
        in_keep   = 8'hFF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_b("reset_out_valid", out_valid, 1'b0);
        check_b("reset_in_ready", in_ready, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_last   = vecs[i].last;
            in_data   = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            in_keep   = 8'(i);
            @(negedge clock);
            check_b($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].ov);
            check_b($sformatf("tbl%0d_in_ready", i), in_ready, vecs[i].ir);
            check_v($sformatf("tbl%0d_data", i), out_data, 64'hDEAD_BEEF_0000_0000 | 64'(i));
            check_b($sformatf("tbl%0d_last", i), out_last, vecs[i].last);
            @(posedge clock);
            #1;
        end

        // inc=1 period=0: one fire per cycle starting at cycle 1.
        set_cfg(1, 0, 8);
        do_reset();
        run_stream(16, 16, 0, 0, -1, 0, 40);
        for (int k = 0; k < 16; k++) check_i($sformatf("cont_fire%0d", k), fire_cyc[k], k + 1);

        // inc=1 period=3 size=1: one fire every 4 cycles.
        set_cfg(1, 3, 1);
        do_reset();
        run_stream(10, 1, 0, 0, -1, 0, 60);
        for (int k = 0; k < 10; k++) check_i($sformatf("slow_fire%0d", k), fire_cyc[k], 4 * (k + 1));

        // Bucket saturates at 8 while idle, then 8-flit burst followed by 4 per 10 cycles.
        set_cfg(4, 9, 8);
        do_reset();
        run_stream(16, 16, 30, 0, -1, 0, 100);
        for (int k = 0; k < 16; k++) begin
            exp_c = (k < 8) ? 30 + k : (k < 12) ? 40 + k - 8 : 50 + k - 12;
            check_i($sformatf("burst_fire%0d", k), fire_cyc[k], exp_c);
        end

        // inc 4 -> 1 after the first flit of a 5-flit packet; takes effect on the next packet.
        set_cfg(4, 9, 8);
        do_reset();
        run_stream(10, 5, 0, 0, 1, 1, 80);
        begin
            int exp_mid[10] = '{10, 11, 12, 13, 20, 21, 22, 23, 30, 40};
            for (int k = 0; k < 10; k++) check_i($sformatf("mid_fire%0d", k), fire_cyc[k], exp_mid[k]);
        end

        // out_ready low 20 cycles with size=2: only 2 stored tokens on release.
        set_cfg(3, 4, 2);
        do_reset();
        run_stream(4, 4, 0, 20, -1, 0, 60);
        begin
            int exp_hold[4] = '{20, 21, 25, 26};
            for (int k = 0; k < 4; k++) check_i($sformatf("hold_fire%0d", k), fire_cyc[k], exp_hold[k]);
        end

        // Reset during the 3rd flit of a packet.
        set_cfg(1, 0, 8);
        do_reset();
        cnt = 0;
        for (int c = 0; c < 10 && cnt < 2; c++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_last   = 1'b0;
            in_data   = 64'(cnt);
            @(negedge clock);
            if (out_valid && out_ready) cnt++;
            @(posedge clock);
            #1;
        end
        check_i("pre_reset_fires", cnt, 2);
        in_data = 64'd2;
        reset   = 1'b1;
        set_cfg(1, 3, 4);
        @(negedge clock);
        check_b("midrst_out_valid", out_valid, 1'b0);
        check_b("midrst_in_ready", in_ready, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        run_stream(2, 2, 0, 0, -1, 0, 40);
        check_i("postrst_fire0", fire_cyc[0], 4);
        check_i("postrst_fire1", fire_cyc[1], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
